// File: rtl/rst_sequencer.sv
// Power-on reset sequencer: holds, filters PLL lock, then releases
// N_CH reset domains in index order; heartbeat LED once running.
module rst_sequencer #(
  parameter int N_CH      = 3,
  parameter int HOLD_CYC  = 16,
  parameter int LOCK_FILT = 4,
  parameter int STAGE_CYC = 8,
  parameter int HB_BIT    = 25,
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lock,
  output logic [N_CH-1:0] rst_out,
  output logic            all_done,
  output logic [SW-1:0]   stage,
  output logic            led
);

  localparam int MAXC = (HOLD_CYC > STAGE_CYC) ? HOLD_CYC : STAGE_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int LW   = $clog2(LOCK_FILT + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYC - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILT - 1);
  localparam logic [SW-1:0] CH_LAST    = SW'(N_CH - 1);

  typedef enum logic [1:0] {
    HOLD,
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  state_t            state_q    = HOLD;
  logic [CW-1:0]     cnt_q      = '0;
  logic [LW-1:0]     lcnt_q     = '0;
  logic [N_CH-1:0]   rst_out_q  = '1;
  logic              all_done_q = 1'b0;
  logic [SW-1:0]     stage_q    = '0;
  logic              led_q      = 1'b1;
  logic [HB_BIT:0]   hb_q       = '0;

  state_t            state_d;
  logic [CW-1:0]     cnt_d;
  logic [LW-1:0]     lcnt_d;
  logic [N_CH-1:0]   rst_out_d;
  logic              all_done_d;
  logic [SW-1:0]     stage_d;
  logic              led_d;
  logic [HB_BIT:0]   hb_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lcnt_d     = lcnt_q;
    rst_out_d  = rst_out_q;
    all_done_d = all_done_q;
    stage_d    = stage_q;
    hb_d       = hb_q + 1'b1;

    unique case (state_q)
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lcnt_d  = '0;
        end
      end
      WAIT_LOCK: begin
        if (!lock) begin
          lcnt_d = '0;
        end else if (lcnt_q == LOCK_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      RELEASE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == STAGE_LAST) begin
          cnt_d     = '0;
          // channels release LSB first, so a shift clears the next bit
          rst_out_d = rst_out_q << 1;
          if (stage_q == CH_LAST) begin
            state_d    = RUN;
            all_done_d = 1'b1;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end
      end
      RUN: begin
      end
      default: state_d = HOLD;
    endcase

    // lock loss overrides any release due on the same edge
    if (!lock && (state_q == RELEASE || state_q == RUN)) begin
      state_d    = WAIT_LOCK;
      cnt_d      = '0;
      lcnt_d     = '0;
      rst_out_d  = '1;
      all_done_d = 1'b0;
      stage_d    = '0;
    end

    if (reset) begin
      state_d    = HOLD;
      cnt_d      = '0;
      lcnt_d     = '0;
      rst_out_d  = '1;
      all_done_d = 1'b0;
      stage_d    = '0;
      hb_d       = '0;
    end

    led_d = (state_d == RUN) ? hb_d[HB_BIT] : 1'b1;
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    lcnt_q     <= lcnt_d;
    rst_out_q  <= rst_out_d;
    all_done_q <= all_done_d;
    stage_q    <= stage_d;
    led_q      <= led_d;
    hb_q       <= hb_d;
  end

  assign rst_out  = rst_out_q;
  assign all_done = all_done_q;
  assign stage    = stage_q;
  assign led      = led_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: timeline-derived expectations queued per
// edge and compared on the falling edge for N_CH=3 and N_CH=1.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lock = 1'b1;
  logic [2:0] rst_out;
  logic       all_done;
  logic [1:0] stage;
  logic       led;
  logic [0:0] rst1;
  logic       done1;
  logic [0:0] stage1;
  logic       led1;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int rb = 20;

  typedef struct {
    int         n;
    logic [2:0] rst;
    logic       done;
    logic [1:0] stg;
    logic       led;
    logic       rst1;
    logic       done1;
    logic       led1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rst_sequencer #(.N_CH(3), .HB_BIT(2)) dut (
    .clk(clk), .reset(reset), .lock(lock),
    .rst_out(rst_out), .all_done(all_done),
    .stage(stage), .led(led)
  );

  rst_sequencer #(.N_CH(1), .HB_BIT(2)) dut1 (
    .clk(clk), .reset(reset), .lock(lock),
    .rst_out(rst1), .all_done(done1),
    .stage(stage1), .led(led1)
  );

  function automatic int released(int t, int rel, int nch);
    int r;
    if (t < rel) return 0;
    r = (t - rel) / 8;
    return (r > nch) ? nch : r;
  endfunction

  task automatic tick(input logic r, input logic l);
    exp_t e;
    int k;
    int k1;
    logic [2:0] ones;
    reset = r;
    lock = l;
    n = r ? 0 : n + 1;
    k  = (r || !l) ? 0 : released(n, rb, 3);
    k1 = (r || !l) ? 0 : released(n, rb, 1);
    ones = 3'b111;
    e.n     = n;
    e.rst   = ones << k;
    e.done  = (k == 3);
    e.stg   = (k == 3) ? 2'd2 : 2'(k);
    e.led   = (k == 3) ? n[2] : 1'b1;
    e.rst1  = (k1 == 0);
    e.done1 = (k1 == 1);
    e.led1  = (k1 == 1) ? n[2] : 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int t,
                     input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got=%b exp=%b", tag, t, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rst_out", e.n, rst_out, e.rst);
      chk("all_done", e.n, {2'b0, all_done}, {2'b0, e.done});
      chk("stage", e.n, {1'b0, stage}, {1'b0, e.stg});
      chk("led", e.n, {2'b0, led}, {2'b0, e.led});
      chk("rst1", e.n, {2'b0, rst1}, {2'b0, e.rst1});
      chk("done1", e.n, {2'b0, done1}, {2'b0, e.done1});
      chk("stage1", e.n, {2'b0, stage1}, 3'b000);
      chk("led1", e.n, {2'b0, led1}, {2'b0, e.led1});
    end
  end

  initial begin
    // power-up, no reset, lock held high
    rb = 20;
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b1);

    // single-cycle lock loss in RUN, lock returns at n=52
    tick(1'b0, 1'b0);
    rb = n + 1 - 1 + 4;
    for (int i = 0; i < 34; i++) tick(1'b0, 1'b1);

    // reset for 3 edges, lock low until n=30
    rb = 1000;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 29; i++) tick(1'b0, 1'b0);
    rb = 30 - 1 + 4;
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b1);

    // reset while rst_out=110, then full rerun
    rb = 20;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b1);

    // lock glitch in WAIT_LOCK: 1,1,1,0 then steady 1 from n=21
    rb = 1000;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    rb = 21 - 1 + 4;
    for (int i = 0; i < 36; i++) tick(1'b0, 1'b1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain got=%0d exp=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised power-on/reset sequencer that releases `N_CH` active-high reset domains one at a time, gated by a filtered PLL-lock input, with a heartbeat status LED. It sits at the top of each FPGA design between the clock source and the functional blocks. It replaces the single fixed power-on reset shift chain and the standalone LED blinker with one configurable block.

## Interface

- `N_CH`, 3, number of reset outputs released in order, index 0 first; ≥1
- `HOLD_CYC`, 16, cycles held in HOLD after reset or power-up; ≥1
- `LOCK_FILT`, 4, consecutive `lock`=1 cycles required before release starts; ≥1
- `STAGE_CYC`, 8, cycles between successive channel releases, including before channel 0; ≥1
- `HB_BIT`, 25, heartbeat counter bit driving `led` in RUN; ≥0

Ports:

- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset/restart request
- `lock`  in  1  PLL locked, already synchronous to `clk`
- `rst_out`  out  N_CH  per-domain reset, active-high, registered
- `all_done`  out  1  high when every `rst_out` bit is 0 (RUN state)
- `stage`  out  max(1,clog2(N_CH))  index of the next channel to release
- `led`  out  1  status: solid 1 while sequencing, blinks in RUN

## Operation

- States: HOLD, WAIT_LOCK, RELEASE, RUN. One shared cycle counter `cnt`, wide enough for max(HOLD_CYC, STAGE_CYC). One lock filter counter `lcnt`. One free-running heartbeat counter `hb` of width HB_BIT+1.
- Reset and power-up values (register initialisers equal the reset values, so configuration behaves like a reset):
  - state=HOLD, cnt=0, lcnt=0
  - rst_out=all 1, all_done=0, stage=0
  - led=1, hb=0
- `reset`=1 at any edge, in any state: the reset values load at that edge. `reset` has priority over everything else.
- HOLD:
  - `lock` is ignored.
  - cnt increments each edge.
  - At the edge where cnt==HOLD_CYC-1: go to WAIT_LOCK, cnt=0, lcnt=0.
- WAIT_LOCK:
  - lock=0 sets lcnt=0.
  - lock=1 increments lcnt.
  - At the edge where lock=1 and lcnt==LOCK_FILT-1: go to RELEASE, cnt=0.
- RELEASE:
  - cnt increments each edge.
  - At the edge where cnt==STAGE_CYC-1: rst_out[stage] goes to 0 and cnt=0.
  - If stage<N_CH-1, stage increments. Otherwise, go to RUN and all_done=1 on the same edge; stage stays N_CH-1.
- RUN: outputs hold. `hb` keeps counting.
- Lock loss: lock=0 sampled in RELEASE or RUN. At that edge:
  - rst_out=all 1, all_done=0, stage=0
  - lcnt=0, cnt=0
  - state=WAIT_LOCK
  - HOLD is not re-entered.
- Lock loss takes precedence over a release scheduled for the same edge.
- led: registered. In RUN, led=hb[HB_BIT]; in any other state, led=1. `hb` is cleared only by `reset`.
- rst_out bits only deassert in index order. Once set, a bit stays 0 until reset or lock loss. All bits reassert together.

## Timing

- Measured from the last edge that samples reset=1 (E0), with lock held 1:
  - WAIT_LOCK entered at E(HOLD_CYC).
  - RELEASE entered at E(HOLD_CYC+LOCK_FILT).
  - rst_out[k] falls at E(HOLD_CYC+LOCK_FILT+(k+1)·STAGE_CYC).
  - all_done rises on the same edge as rst_out[N_CH-1] falls.
- With defaults, rst_out[0..2] fall at E28, E36, E44; all_done=1 after E44.
- From power-up without reset, the same numbers apply, counting the first clock edge as E1.
- Lock loss: all rst_out=1 on the edge that samples lock=0, i.e. 1-cycle latency.
- After lock returns at edge Lr, release restarts:
  - rst_out[0] falls at E(Lr-1+LOCK_FILT+STAGE_CYC), counting Lr as the first lock=1 sample.
  - With defaults: Lr+11.
- `lock` glitch in WAIT_LOCK restarts the filter; any single 0 sample clears lcnt.
- Reset mid-RELEASE: all rst_out=1 at that edge, and the full HOLD→WAIT_LOCK→RELEASE sequence reruns.
- No combinational path from inputs to outputs.

## Test plan

- Defaults, HB_BIT=2, reset 1 for 3 edges, then 0, lock=1 → rst_out=111 until E28; 110 at E28; 100 at E36; 000 and all_done=1 at E44; stage 0→1→2. Afterwards led toggles every 4 cycles.
- Power-up with no reset, lock=1 → identical release edges E28/E36/E44, counting from the first edge.
- lock=0 until E30, then 1 → WAIT_LOCK holds with rst_out=111. Counting E30 as the first lock=1 sample, rst_out[0] falls at E30+3+8=E41.
- lock pulses 1,1,1,0,1,1,1,1 in WAIT_LOCK → release starts only after the final 4-run. No release is triggered by the first 3-run.
- In RUN, lock=0 for one cycle → rst_out=111, all_done=0, stage=0, led=1 on that edge. Re-release then follows the lock-loss timing.
- reset=1 for one cycle when rst_out=110 → 111 at that edge. rst_out[0] next falls 28 edges later. N_CH=1 variant: rst_out falls and all_done rises together at E28.
